// File: rtl/cmd_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS command streams into one registered
// AXI-Stream output, buffered by a 2-entry (main + skid) output stage.
//
// state  | meaning
// IDLE   | no grant held; picks the next requester round-robin from rr_ptr
// STREAM | forwards the granted port until its tlast beat is accepted
module cmd_stream_arbiter #(
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int NUM_PORTS        = 2,
    parameter int ID_WIDTH         = 2
) (
    input  logic                                  aclk,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  s_cmd_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_cmd_axis_tready,
    input  logic [NUM_PORTS-1:0]                  s_cmd_axis_tlast,
    input  logic [NUM_PORTS*CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
    output logic                                  m_cmd_axis_tvalid,
    input  logic                                  m_cmd_axis_tready,
    output logic                                  m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0]           m_cmd_axis_tdata,
    output logic [ID_WIDTH-1:0]                   m_cmd_axis_tid,
    output logic                                  dbg_state,
    output logic [ID_WIDTH-1:0]                   dbg_grant
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state;
    logic [ID_WIDTH-1:0]         rr_ptr;
    logic [ID_WIDTH-1:0]         grant;

    logic                        main_valid;
    logic [CMD_STREAM_WIDTH-1:0] main_data;
    logic                        main_last;
    logic [ID_WIDTH-1:0]         main_tid;
    logic                        skid_valid;
    logic [CMD_STREAM_WIDTH-1:0] skid_data;
    logic                        skid_last;
    logic [ID_WIDTH-1:0]         skid_tid;

    logic                        sel_valid;
    logic                        sel_last;
    logic [CMD_STREAM_WIDTH-1:0] sel_data;
    logic                        req_found;
    logic [ID_WIDTH-1:0]         req_port;
    int                          best_dist;
    logic                        accept;
    logic [ID_WIDTH-1:0]         grant_next;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_valid = s_cmd_axis_tvalid[i];
                sel_last  = s_cmd_axis_tlast[i];
                sel_data  = s_cmd_axis_tdata[i*CMD_STREAM_WIDTH +: CMD_STREAM_WIDTH];
            end
        end
    end

    // Pick the requester closest to rr_ptr going upward, wrapping at NUM_PORTS.
    always_comb begin
        req_found = 1'b0;
        req_port  = '0;
        best_dist = NUM_PORTS;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (s_cmd_axis_tvalid[j] &&
                ((j + NUM_PORTS - int'(rr_ptr)) % NUM_PORTS) < best_dist) begin
                best_dist = (j + NUM_PORTS - int'(rr_ptr)) % NUM_PORTS;
                req_found = 1'b1;
                req_port  = ID_WIDTH'(j);
            end
        end
    end

    always_comb begin
        s_cmd_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state == STREAM && grant == ID_WIDTH'(i)) begin
                s_cmd_axis_tready[i] = ~skid_valid;
            end
        end
    end

    assign accept     = (state == STREAM) && sel_valid && !skid_valid;
    assign grant_next = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + ID_WIDTH'(1);

    always_ff @(posedge aclk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            main_tid   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_tid   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        grant <= req_port;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept && sel_last) begin
                        rr_ptr <= grant_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Skid only fills while main is stalled, so it drains first when main frees up.
            if (m_cmd_axis_tready || !main_valid) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_last  <= skid_last;
                    main_tid   <= skid_tid;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= sel_data;
                    main_last  <= sel_last;
                    main_tid   <= grant;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= sel_data;
                skid_last  <= sel_last;
                skid_tid   <= grant;
            end
        end
    end

    assign m_cmd_axis_tvalid = main_valid;
    assign m_cmd_axis_tlast  = main_last;
    assign m_cmd_axis_tdata  = main_data;
    assign m_cmd_axis_tid    = main_tid;
    assign dbg_state         = (state == STREAM);
    assign dbg_grant         = grant;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed bench for cmd_stream_arbiter with three sources: single port, contention,
// backpressure, source bubble, mid-packet reset and single-beat round robin.
module tb_cmd_stream_arbiter;
    localparam int W  = 32;
    localparam int NP = 3;
    localparam int IW = 2;

    logic            aclk = 1'b0;
    logic            reset;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tready;
    logic [NP-1:0]   s_tlast;
    logic [NP*W-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [W-1:0]    m_tdata;
    logic [IW-1:0]   m_tid;
    logic            dbg_state;
    logic [IW-1:0]   dbg_grant;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    logic [NP-1:0] hold;
    logic [34:0] out_q[$];
    int          out_cyc[$];
    logic        stab_en;
    logic        prev_v;
    logic        prev_r;
    logic [34:0] prev_beat;

    cmd_stream_arbiter #(
        .CMD_STREAM_WIDTH(W),
        .NUM_PORTS(NP),
        .ID_WIDTH(IW)
    ) dut (
        .aclk(aclk),
        .reset(reset),
        .s_cmd_axis_tvalid(s_tvalid),
        .s_cmd_axis_tready(s_tready),
        .s_cmd_axis_tlast(s_tlast),
        .s_cmd_axis_tdata(s_tdata),
        .m_cmd_axis_tvalid(m_tvalid),
        .m_cmd_axis_tready(m_tready),
        .m_cmd_axis_tlast(m_tlast),
        .m_cmd_axis_tdata(m_tdata),
        .m_cmd_axis_tid(m_tid),
        .dbg_state(dbg_state),
        .dbg_grant(dbg_grant)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] bt(input int id, input logic l, input logic [31:0] d);
        logic [1:0] idv;
        idv = id[1:0];
        return {idv, l, d};
    endfunction

    task automatic drive_srcs();
        logic [32:0] h;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        if (q0.size() > 0 && !hold[0]) begin
            h = q0[0];
            s_tvalid[0] = 1'b1; s_tlast[0] = h[32]; s_tdata[0*W +: W] = h[31:0];
        end
        if (q1.size() > 0 && !hold[1]) begin
            h = q1[0];
            s_tvalid[1] = 1'b1; s_tlast[1] = h[32]; s_tdata[1*W +: W] = h[31:0];
        end
        if (q2.size() > 0 && !hold[2]) begin
            h = q2[0];
            s_tvalid[2] = 1'b1; s_tlast[2] = h[32]; s_tdata[2*W +: W] = h[31:0];
        end
    endtask

    task automatic tick();
        logic [NP-1:0] acc;
        drive_srcs();
        @(negedge aclk);
        cyc++;
        acc = s_tvalid & s_tready;
        if (stab_en && prev_v && !prev_r)
            check("hold_stable", {m_tvalid, m_tid, m_tlast, m_tdata}, {1'b1, prev_beat});
        prev_v    = m_tvalid;
        prev_r    = m_tready;
        prev_beat = {m_tid, m_tlast, m_tdata};
        if (m_tvalid && m_tready) begin
            out_q.push_back({m_tid, m_tlast, m_tdata});
            out_cyc.push_back(cyc);
        end
        @(posedge aclk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        if (acc[2]) void'(q2.pop_front());
    endtask

    task automatic collect(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && out_q.size() < n; k++) tick();
        check(tag, out_q.size(), n);
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; m_tready = 1'b1; hold = '0; stab_en = 1'b0;
        prev_v = 1'b0; prev_r = 1'b0; prev_beat = '0;
        tick();
        tick();
        check("rst_m_outputs", {m_tvalid, m_tlast, m_tid, m_tdata}, '0);
        check("rst_s_tready", s_tready, '0);
        check("rst_dbg", {dbg_state, dbg_grant}, '0);
        reset = 1'b0;

        // single port, 4 beats
        clear_out();
        for (int i = 0; i < 4; i++) q0.push_back({i == 3, 32'h10 + 32'(i)});
        t0 = cyc;
        collect("t1_count", 4, 20);
        check("t1_latency", out_cyc[0] - t0, 3);
        for (int i = 0; i < 4; i++) begin
            check("t1_beat", out_q[i], bt(0, i == 3, 32'h10 + 32'(i)));
            if (i > 0) check("t1_gap", out_cyc[i] - out_cyc[i-1], 1);
        end
        tick(); tick();

        // contention: two 3-beat packets from each of port0 and port1
        do_reset();
        clear_out();
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 3; b++) begin
                q0.push_back({b == 2, 32'hA0 + 32'(b)});
                q1.push_back({b == 2, 32'hB0 + 32'(b)});
            end
        collect("t2_count", 12, 80);
        for (int i = 0; i < 12; i++) begin
            check("t2_beat", out_q[i], bt((i / 3) % 2, (i % 3) == 2,
                  (((i / 3) % 2) == 1 ? 32'hB0 : 32'hA0) + 32'(i % 3)));
            if (i > 0) check("t2_gap", out_cyc[i] - out_cyc[i-1], (i % 3 == 0) ? 2 : 1);
        end
        tick(); tick();

        // backpressure: ready pattern 1,0,0 repeating over a 6-beat packet
        clear_out();
        for (int i = 0; i < 6; i++) q0.push_back({i == 5, 32'h30 + 32'(i)});
        stab_en = 1'b1;
        for (int k = 0; k < 80 && out_q.size() < 6; k++) begin
            m_tready = (k % 3 == 0);
            tick();
        end
        stab_en  = 1'b0;
        m_tready = 1'b1;
        check("t3_count", out_q.size(), 6);
        for (int i = 0; i < 6; i++) check("t3_beat", out_q[i], bt(0, i == 5, 32'h30 + 32'(i)));
        tick(); tick();

        // source bubble: port1 granted (rr_ptr = 1), stalls 3 cycles while port0 waits
        clear_out();
        for (int i = 0; i < 5; i++) q1.push_back({i == 4, 32'h40 + 32'(i)});
        q0.push_back({1'b0, 32'h50});
        q0.push_back({1'b1, 32'h51});
        for (int k = 0; k < 20 && q1.size() > 3; k++) tick();
        check("t4_two_accepted", q1.size(), 3);
        hold[1] = 1'b1;
        tick(); tick(); tick();
        check("t4_bubble_state", dbg_state, 1);
        check("t4_bubble_grant", dbg_grant, 1);
        check("t4_port0_ready", s_tready[0], 0);
        hold[1] = 1'b0;
        collect("t4_count", 7, 40);
        for (int i = 0; i < 5; i++) check("t4_beat_p1", out_q[i], bt(1, i == 4, 32'h40 + 32'(i)));
        check("t4_beat_p0a", out_q[5], bt(0, 1'b0, 32'h50));
        check("t4_beat_p0b", out_q[6], bt(0, 1'b1, 32'h51));
        tick(); tick();

        // reset after beat 2 of a 5-beat port1 packet; rr_ptr must return to 0
        clear_out();
        for (int i = 0; i < 5; i++) q1.push_back({i == 4, 32'h70 + 32'(i)});
        for (int k = 0; k < 20 && q1.size() > 3; k++) tick();
        check("t5_two_accepted", q1.size(), 3);
        reset = 1'b1;
        tick();
        check("t5_rst_m_outputs", {m_tvalid, m_tlast, m_tid, m_tdata}, '0);
        check("t5_rst_s_tready", s_tready, '0);
        check("t5_rst_state", dbg_state, 0);
        reset = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        clear_out();
        q0.push_back({1'b0, 32'h60});
        q0.push_back({1'b1, 32'h61});
        q1.push_back({1'b1, 32'h78});
        collect("t5_count", 3, 30);
        check("t5_first", out_q[0], bt(0, 1'b0, 32'h60));
        check("t5_second", out_q[1], bt(0, 1'b1, 32'h61));
        check("t5_third", out_q[2], bt(1, 1'b1, 32'h78));
        tick(); tick();

        // single-beat packets from all three ports
        do_reset();
        clear_out();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 32'h80 + 32'(i)});
            q1.push_back({1'b1, 32'h90 + 32'(i)});
            q2.push_back({1'b1, 32'hA0 + 32'(i)});
        end
        collect("t6_count", 12, 60);
        for (int i = 0; i < 12; i++) begin
            check("t6_beat", out_q[i], bt(i % 3, 1'b1,
                  (i % 3 == 0 ? 32'h80 : (i % 3 == 1 ? 32'h90 : 32'hA0)) + 32'(i / 3)));
            if (i > 0) check("t6_gap", out_cyc[i] - out_cyc[i-1], 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
